afe_spi_multichannel: RTL and testbench



---
 rtl/afe_spi_multichannel.sv | 175 +++++++++++++++++
 tb/tb_afe_spi_multichannel.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/afe_spi_multichannel.sv
// afe_spi_multichannel
// Serial-write controller for the AFE attenuator/switch chains. One command
// shifts a DATA_WIDTH word MSB first onto every link selected by cmdMask,
// then pulses LE on those links. Unselected links stay at 0.
//
// Optional build macro: AFE_SPI_READBACK_EN adds spiSdo/rdData/rdValid and
// captures a word from the lowest-indexed selected link during the shift.
// With the macro undefined those ports and the capture logic are absent.
module afe_spi_multichannel #(
  parameter int CHANNEL_COUNT = 2,
  parameter int DATA_WIDTH    = 24,
  parameter int CLK_DIV       = 4
) (
  input  logic                     sysClk,
  input  logic                     sysReset_n,
  input  logic                     cmdValid,
  output logic                     cmdReady,
  input  logic [CHANNEL_COUNT-1:0] cmdMask,
  input  logic [DATA_WIDTH-1:0]    cmdData,
  output logic                     done,
  output logic [CHANNEL_COUNT-1:0] spiClk,
  output logic [CHANNEL_COUNT-1:0] spiSdi,
  output logic [CHANNEL_COUNT-1:0] spiLe
`ifdef AFE_SPI_READBACK_EN
  ,
  input  logic [CHANNEL_COUNT-1:0] spiSdo,
  output logic [DATA_WIDTH-1:0]    rdData,
  output logic                     rdValid
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    LE_SETUP = 2'd2,
    LE_PULSE = 2'd3
  } state_t;

  state_t                   state;
  logic [CHANNEL_COUNT-1:0] mask_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [BIT_W-1:0]         bit_cnt;
  logic [DIV_W-1:0]         div_cnt;
  logic                     phase_hi;
  logic                     div_last;
  logic [BIT_W-1:0]         next_bit;

  // Last sysClk cycle of the current half-period / LE phase.
  assign div_last = (div_cnt == DIV_LAST);
  assign next_bit = bit_cnt - BIT_ONE;

  // Command FSM; every pin and handshake output is a register of this block.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state    <= IDLE;
      mask_q   <= '0;
      data_q   <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      phase_hi <= 1'b0;
      cmdReady <= 1'b0;
      done     <= 1'b0;
      spiClk   <= '0;
      spiSdi   <= '0;
      spiLe    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          cmdReady <= 1'b1;
          if (cmdValid && cmdReady && (|cmdMask)) begin
            mask_q   <= cmdMask;
            data_q   <= cmdData;
            bit_cnt  <= BIT_LAST;
            div_cnt  <= '0;
            phase_hi <= 1'b0;
            cmdReady <= 1'b0;
            spiClk   <= '0;
            spiSdi   <= cmdMask & {CHANNEL_COUNT{cmdData[DATA_WIDTH-1]}};
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (!div_last) begin
            div_cnt <= div_cnt + DIV_ONE;
          end else begin
            div_cnt <= '0;
            if (!phase_hi) begin
              phase_hi <= 1'b1;
              spiClk   <= mask_q;
            end else if (bit_cnt == '0) begin
              phase_hi <= 1'b0;
              spiClk   <= '0;
              spiSdi   <= '0;
              state    <= LE_SETUP;
            end else begin
              phase_hi <= 1'b0;
              bit_cnt  <= next_bit;
              spiClk   <= '0;
              spiSdi   <= mask_q & {CHANNEL_COUNT{data_q[next_bit]}};
            end
          end
        end

        LE_SETUP: begin
          if (!div_last) begin
            div_cnt <= div_cnt + DIV_ONE;
          end else begin
            div_cnt <= '0;
            spiLe   <= mask_q;
            state   <= LE_PULSE;
          end
        end

        LE_PULSE: begin
          if (!div_last) begin
            div_cnt <= div_cnt + DIV_ONE;
          end else begin
            div_cnt  <= '0;
            spiLe    <= '0;
            cmdReady <= 1'b1;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef AFE_SPI_READBACK_EN
  logic [DATA_WIDTH-1:0] rd_shift;
  logic                  sdo_bit;

  // Readback source is the lowest-indexed link selected by the command.
  // NOTE: the default assignment first keeps this combinational block from
  // inferring a latch when no mask bit is set.
  always_comb begin
    sdo_bit = 1'b0;
    for (int i = CHANNEL_COUNT - 1; i >= 0; i--) begin
      if (mask_q[i]) sdo_bit = spiSdo[i];
    end
  end

  // Sample SDO at the end of each spiClk-high phase; publish on completion.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      rd_shift <= '0;
      rdData   <= '0;
      rdValid  <= 1'b0;
    end else begin
      rdValid <= 1'b0;
      if (state == SHIFT && phase_hi && div_last) begin
        rd_shift <= (rd_shift << 1) | DATA_WIDTH'(sdo_bit);
      end
      if (state == LE_PULSE && div_last) begin
        rdData  <= rd_shift;
        rdValid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_afe_spi_multichannel.sv
// Testbench for afe_spi_multichannel with default parameters
// (2 links, 24-bit words, CLK_DIV=4). Table-driven command vectors plus
// hand-written sequences for reset, back-to-back and mid-transfer reset.
module tb_afe_spi_multichannel;

  localparam int CC   = 2;
  localparam int DW   = 24;
  localparam int CD   = 4;
  localparam int BUSY = (2 * DW + 2) * CD;  // 200 cycles with defaults

  logic          sysClk = 1'b0;
  logic          sysReset_n;
  logic          cmdValid;
  logic          cmdReady;
  logic [CC-1:0] cmdMask;
  logic [DW-1:0] cmdData;
  logic          done;
  logic [CC-1:0] spiClk;
  logic [CC-1:0] spiSdi;
  logic [CC-1:0] spiLe;
`ifdef AFE_SPI_READBACK_EN
  logic [CC-1:0] spiSdo;
  logic [DW-1:0] rdData;
  logic          rdValid;
  assign spiSdo = spiSdi;  // loop each link back on itself
`endif

  int checks = 0;
  int errors = 0;

  afe_spi_multichannel #(
    .CHANNEL_COUNT(CC),
    .DATA_WIDTH   (DW),
    .CLK_DIV      (CD)
  ) dut (
    .sysClk    (sysClk),
    .sysReset_n(sysReset_n),
    .cmdValid  (cmdValid),
    .cmdReady  (cmdReady),
    .cmdMask   (cmdMask),
    .cmdData   (cmdData),
    .done      (done),
    .spiClk    (spiClk),
    .spiSdi    (spiSdi),
    .spiLe     (spiLe)
`ifdef AFE_SPI_READBACK_EN
    ,
    .spiSdo    (spiSdo),
    .rdData    (rdData),
    .rdValid   (rdValid)
`endif
  );

  always #5 sysClk = ~sysClk;

  typedef struct {
    logic [CC-1:0] mask;
    logic [DW-1:0] data;
    int            exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) until the block is ready, sampling on falling edges.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmdReady !== 1'b1 && n < 1000) begin
      @(negedge sysClk);
      n++;
    end
    check({tag, " ready"}, {31'd0, cmdReady}, 32'd1);
  endtask

  // Issue one command and observe every link until done (or a cycle budget).
  task automatic run_cmd(input logic [CC-1:0] mask, input logic [DW-1:0] data,
                         input int exp_busy, input logic exp_done, input string tag);
    int            busy = 0;
    int            done_at = 0;
    int            unstable = 0;
    logic          ready_at_done = 1'b0;
    int            pulses[CC];
    int            hi_cyc[CC];
    int            le_cyc[CC];
    logic [DW-1:0] word[CC];
    logic [CC-1:0] prev_clk = '0;
    logic [CC-1:0] prev_sdi = '0;
    for (int l = 0; l < CC; l++) begin
      pulses[l] = 0; hi_cyc[l] = 0; le_cyc[l] = 0; word[l] = '0;
    end
    wait_ready(tag);
    cmdValid = 1'b1;
    cmdMask  = mask;
    cmdData  = data;
    @(negedge sysClk);
    // Scramble the command inputs: the block must use its registered copy.
    cmdValid = 1'b0;
    cmdMask  = ~mask;
    cmdData  = ~data;
    for (int c = 1; c <= BUSY + 20; c++) begin
      if (c > 1) @(negedge sysClk);
      if (!cmdReady) busy++;
      for (int l = 0; l < CC; l++) begin
        if (spiClk[l] && !prev_clk[l]) begin
          pulses[l]++;
          word[l] = {word[l][DW-2:0], spiSdi[l]};
        end
        if (c > 1 && spiClk[l] == prev_clk[l] && spiSdi[l] != prev_sdi[l]) unstable++;
        if (spiClk[l]) hi_cyc[l]++;
        if (spiLe[l]) le_cyc[l]++;
      end
      prev_clk = spiClk;
      prev_sdi = spiSdi;
      if (done) begin
        done_at       = c;
        ready_at_done = cmdReady;
`ifdef AFE_SPI_READBACK_EN
        check({tag, " rdValid"}, {31'd0, rdValid}, 32'd1);
        check({tag, " rdData"}, 32'(rdData), 32'(data));
`endif
        break;
      end
    end
    check({tag, " busy cycles"}, 32'(busy), 32'(exp_busy));
    check({tag, " done cycle"}, 32'(done_at), exp_done ? 32'(exp_busy + 1) : 32'd0);
    check({tag, " ready at done"}, {31'd0, ready_at_done}, {31'd0, exp_done});
    check({tag, " sdi stability"}, 32'(unstable), 32'd0);
    for (int l = 0; l < CC; l++) begin
      check($sformatf("%s link%0d word", tag, l), 32'(word[l]), mask[l] ? 32'(data) : 32'd0);
      check($sformatf("%s link%0d pulses", tag, l), 32'(pulses[l]), mask[l] ? 32'(DW) : 32'd0);
      check($sformatf("%s link%0d clk high", tag, l), 32'(hi_cyc[l]), mask[l] ? 32'(DW * CD) : 32'd0);
      check($sformatf("%s link%0d le cycles", tag, l), 32'(le_cyc[l]), mask[l] ? 32'(CD) : 32'd0);
    end
  endtask

  function automatic logic [31:0] pins();
    return 32'({cmdReady, done, spiClk, spiSdi, spiLe});
  endfunction

  initial begin
    int bad;
    int n;
    int diffs;
    logic [DW-1:0] w0;
    logic [CC-1:0] p;

    vecs[0] = '{mask: 2'b01, data: 24'hA5C3F0, exp_busy: BUSY, exp_done: 1'b1};
    vecs[1] = '{mask: 2'b10, data: 24'h3C5A96, exp_busy: BUSY, exp_done: 1'b1};
    vecs[2] = '{mask: 2'b11, data: 24'h800000, exp_busy: BUSY, exp_done: 1'b1};
    vecs[3] = '{mask: 2'b00, data: 24'hFFFFFF, exp_busy: 0,    exp_done: 1'b0};
    vecs[4] = '{mask: 2'b11, data: 24'hFFFFFF, exp_busy: BUSY, exp_done: 1'b1};

    sysReset_n = 1'b0;
    cmdValid   = 1'b0;
    cmdMask    = '0;
    cmdData    = '0;

    // Reset release: everything held at 0, ready one edge after release.
    bad = 0;
    repeat (5) begin
      @(negedge sysClk);
      if (pins() != 32'd0) bad++;
    end
    check("reset pins", 32'(bad), 32'd0);
    sysReset_n = 1'b1;
    #1;
    check("ready at release", {31'd0, cmdReady}, 32'd0);
    @(negedge sysClk);
    check("ready after first edge", {31'd0, cmdReady}, 32'd1);

    // Table-driven commands.
    for (int v = 0; v < 5; v++) begin
      run_cmd(vecs[v].mask, vecs[v].data, vecs[v].exp_busy, vecs[v].exp_done,
              $sformatf("vec%0d", v));
    end

    // Broadcast with a second command held valid across done.
    wait_ready("b2b");
    cmdValid = 1'b1;
    cmdMask  = 2'b11;
    cmdData  = 24'h000001;
    @(negedge sysClk);
    cmdMask  = 2'b01;
    cmdData  = 24'h800000;
    diffs = 0;
    w0 = '0;
    p = '0;
    n = 0;
    for (int c = 1; c <= BUSY + 20; c++) begin
      if (c > 1) @(negedge sysClk);
      if (spiClk[0] != spiClk[1] || spiSdi[0] != spiSdi[1] || spiLe[0] != spiLe[1]) diffs++;
      if (spiClk[0] && !p[0]) w0 = {w0[DW-2:0], spiSdi[0]};
      p = spiClk;
      if (done) begin
        n = c;
        break;
      end
    end
    check("b2b identical links", 32'(diffs), 32'd0);
    check("b2b word", 32'(w0), 32'h000001);
    check("b2b done cycle", 32'(n), 32'(BUSY + 1));
    check("b2b ready with done", {31'd0, cmdReady}, 32'd1);
    @(negedge sysClk);
    cmdValid = 1'b0;
    check("b2b second accepted", {31'd0, cmdReady}, 32'd0);
    check("b2b second msb", 32'(spiSdi), 32'h1);
    n = 0;
    while (!done && n < BUSY + 20) begin
      @(negedge sysClk);
      n++;
    end
    check("b2b second done", {31'd0, done}, 32'd1);

    // Reset in the middle of bit 10, then a fresh command.
    wait_ready("mid");
    cmdValid = 1'b1;
    cmdMask  = 2'b01;
    cmdData  = 24'hA5C3F0;
    @(negedge sysClk);
    cmdValid = 1'b0;
    n = 0;
    p = '0;
    for (int c = 0; c < BUSY && n < 11; c++) begin
      if (spiClk[0] && !p[0]) n++;
      p = spiClk;
      if (n < 11) @(negedge sysClk);
    end
    check("mid reached bit 10", 32'(n), 32'd11);
    #2;
    sysReset_n = 1'b0;
    #1;
    check("mid async reset pins", pins(), 32'd0);
    repeat (3) @(negedge sysClk);
    check("mid held reset pins", pins(), 32'd0);
    sysReset_n = 1'b1;
    @(negedge sysClk);
    run_cmd(2'b10, 24'h5A5A5A, BUSY, 1'b1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
